// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between IF and data requesters with a timeout watchdog
module mem_port_arbiter #(
    parameter int          TIMEOUT  = 15,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        err
);
    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CMAX = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_D, RESP_IF, RESP_D} state_t;

    state_t        state;
    logic          last_d;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          fin;
    logic          go_d;
    logic          go_if;
    logic [31:0]   rd_val;

    // grant decision: data wins ties unless it had the last grant; in RESP only the other side is eligible
    always_comb begin
        busy   = (state == BUSY_IF) || (state == BUSY_D);
        fin    = m_ready || (cnt == CMAX);
        rd_val = m_ready ? m_rdata : ERR_DATA;
        go_d   = ((state == IDLE) && d_req && !(if_req && last_d)) || ((state == RESP_IF) && d_req);
        go_if  = ((state == IDLE) && if_req && !go_d) || ((state == RESP_D) && if_req);
    end

    // transaction sequencer with registered memory and requester outputs
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            cnt      <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            err      <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            if (busy) begin
                if (fin) begin
                    state    <= (state == BUSY_IF) ? RESP_IF : RESP_D;
                    if_ready <= (state == BUSY_IF);
                    d_ready  <= (state == BUSY_D);
                    m_req    <= 1'b0;
                    m_we     <= 1'b0;
                    cnt      <= '0;
                    if (!m_ready) err <= 1'b1;
                    if (state == BUSY_IF) if_rdata <= rd_val;
                    else if (!m_we) d_rdata <= rd_val;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (go_d) begin
                state   <= BUSY_D;
                last_d  <= 1'b1;
                m_req   <= 1'b1;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
            end else if (go_if) begin
                state   <= BUSY_IF;
                last_d  <= 1'b0;
                m_req   <= 1'b1;
                m_we    <= 1'b0;
                m_addr  <= if_addr;
                m_wdata <= '0;
            end else if (state != IDLE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        clrn;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter dut (
        .clk(clk), .clrn(clrn),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        clrn = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; m_rdata = '0; m_ready = 1'b0;
        tick(); tick();
        chk("rst_m_req", m_req, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_m_addr", m_addr, 0);
        clrn = 1'b1;
        tick();

        // single IF read
        if_req = 1'b1; if_addr = 32'h40;
        tick();
        chk("if1_m_req", m_req, 1);
        chk("if1_m_addr", m_addr, 32'h40);
        chk("if1_m_we", m_we, 0);
        chk("if1_ready_early", if_ready, 0);
        m_ready = 1'b1; m_rdata = 32'h2002000A;
        tick();
        chk("if1_ready", if_ready, 1);
        chk("if1_rdata", if_rdata, 32'h2002000A);
        chk("if1_m_req_clr", m_req, 0);
        chk("if1_d_ready", d_ready, 0);
        if_req = 1'b0; m_ready = 1'b0;
        tick();
        chk("if1_ready_once", if_ready, 0);

        // simultaneous after reset: data first, then IF back-to-back
        clrn = 1'b0; tick(); clrn = 1'b1;
        if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        tick();
        chk("sim_d_first_addr", m_addr, 32'h100);
        chk("sim_d_m_we", m_we, 0);
        m_ready = 1'b1; m_rdata = 32'hAAAA0001;
        tick();
        chk("sim_d_ready", d_ready, 1);
        chk("sim_d_rdata", d_rdata, 32'hAAAA0001);
        chk("sim_if_ready_excl", if_ready, 0);
        d_req = 1'b0; m_ready = 1'b0;
        tick();
        chk("sim_b2b_m_req", m_req, 1);
        chk("sim_b2b_addr", m_addr, 32'h200);
        m_ready = 1'b1; m_rdata = 32'hBBBB0002;
        tick();
        chk("sim_if_ready", if_ready, 1);
        chk("sim_if_rdata", if_rdata, 32'hBBBB0002);
        if_req = 1'b0; m_ready = 1'b0;
        tick();

        // data write, with attribute stability during BUSY
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h12345678;
        tick();
        chk("wr_m_we", m_we, 1);
        chk("wr_m_wdata", m_wdata, 32'h12345678);
        chk("wr_m_addr", m_addr, 32'h8);
        d_wdata = 32'h0; d_addr = 32'hFC;
        tick();
        chk("wr_stable_wdata", m_wdata, 32'h12345678);
        chk("wr_stable_addr", m_addr, 32'h8);
        m_ready = 1'b1; m_rdata = 32'h55555555;
        tick();
        chk("wr_d_ready", d_ready, 1);
        chk("wr_d_rdata_kept", d_rdata, 32'hAAAA0001);
        chk("wr_m_we_clr", m_we, 0);
        d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0;
        tick();

        // both requesting with last grant = D: IF first, then data back-to-back
        if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_addr = 32'h104;
        tick();
        chk("alt_if_first", m_addr, 32'h300);
        m_ready = 1'b1; m_rdata = 32'hCCCC0003;
        tick();
        chk("alt_if_ready", if_ready, 1);
        chk("alt_if_rdata", if_rdata, 32'hCCCC0003);
        if_req = 1'b0; m_ready = 1'b0;
        tick();
        chk("alt_d_addr", m_addr, 32'h104);
        chk("alt_d_m_req", m_req, 1);
        m_ready = 1'b1; m_rdata = 32'hDDDD0004;
        tick();
        chk("alt_d_rdata", d_rdata, 32'hDDDD0004);
        d_req = 1'b0; m_ready = 1'b0;
        tick();

        // timeout on a data read
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("to_still_busy", m_req, 1);
        chk("to_no_ready", d_ready, 0);
        chk("to_err_early", err, 0);
        tick();
        chk("to_d_ready", d_ready, 1);
        chk("to_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("to_err", err, 1);
        chk("to_m_req_clr", m_req, 0);
        d_req = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'h44;
        tick();
        m_ready = 1'b1; m_rdata = 32'h11112222;
        tick();
        chk("to_if_ready", if_ready, 1);
        chk("to_if_rdata", if_rdata, 32'h11112222);
        chk("to_err_sticky", err, 1);
        if_req = 1'b0; m_ready = 1'b0;
        tick();

        // reset in the middle of a data transaction
        d_req = 1'b1; d_addr = 32'h30;
        tick();
        chk("rm_busy", m_req, 1);
        #2 clrn = 1'b0;
        #1;
        chk("rm_m_req_async", m_req, 0);
        chk("rm_err_clr", err, 0);
        d_req = 1'b0; if_req = 1'b1; if_addr = 32'h50;
        tick();
        chk("rm_no_d_ready", d_ready, 0);
        clrn = 1'b1;
        tick();
        chk("rm_if_grant", m_addr, 32'h50);
        chk("rm_no_d_ready2", d_ready, 0);
        m_ready = 1'b1; m_rdata = 32'h0BADF00D;
        tick();
        chk("rm_if_ready", if_ready, 1);
        chk("rm_no_d_ready3", d_ready, 0);

        // stale IF request held high: one IDLE cycle between transactions
        if_addr = 32'h54; m_ready = 1'b0;
        tick();
        chk("st_idle_no_grant", m_req, 0);
        chk("st_idle_no_ready", if_ready, 0);
        tick();
        chk("st_regrant", m_req, 1);
        chk("st_regrant_addr", m_addr, 32'h54);
        m_ready = 1'b1; m_rdata = 32'h77778888;
        tick();
        chk("st_if_rdata", if_rdata, 32'h77778888);
        if_req = 1'b0; m_ready = 1'b0;
        tick();

        // m_ready while IDLE is ignored
        m_ready = 1'b1; m_rdata = 32'h99;
        tick();
        chk("idle_ign_ready", if_ready, 0);
        chk("idle_ign_rdata", if_rdata, 32'h77778888);
        chk("idle_ign_d_ready", d_ready, 0);
        m_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
